// File: rtl/instr_seq_pkg.sv
// Shared decode constants and FSM state type for the instruction sequencer.
// Opcode values must track the control unit's decoder.
package instr_seq_pkg;
  localparam int OPC_W = 6;
  localparam int OPR_W = 10;

  localparam logic [OPC_W-1:0] OPC_JUMPNZ = 6'd47;
  localparam logic [OPC_W-1:0] OPC_JUMPZ  = 6'd51;
  localparam logic [OPC_W-1:0] OPC_NOP    = 6'd46;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_DISPATCH,
    S_DONE
  } state_t;

  function automatic logic is_jump(input logic [OPC_W-1:0] opc);
    return (opc == OPC_JUMPNZ) || (opc == OPC_JUMPZ);
  endfunction
endpackage

// File: rtl/instr_sequencer_pc_unit.sv
// pc_unit: program counter with clear/load/saturating increment; illegal flags pc >= INST_DEPTH.
// Latency: one cycle from control to new pc; no backpressure (controls are single-cycle strobes).
module pc_unit #(
  parameter int ADDR_W     = 10,
  parameter int INST_DEPTH = 166
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              illegal
);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(INST_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      // Saturate at DEPTH so a run-off program faults on the next fetch instead of wrapping.
      pc <= (pc >= DEPTH - ADDR_W'(1)) ? DEPTH : pc + ADDR_W'(1);
    end
  end

  assign illegal = (pc >= DEPTH);
endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: FETCH/LATCH/DISPATCH per instruction, jumps resolved locally, others handed off via instr_valid/exec_done.
// Latency 3 cycles per jump/NOP, 3+k otherwise; DISPATCH holds until exec_done (and step when INSTR_SEQ_STEP_EN is defined).
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int INST_DEPTH = 166,
  parameter int INSTR_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef INSTR_SEQ_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               z_flag,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] ir,
  input  logic               exec_done,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        retired
);
  state_t            state;
  logic              resolved;
  logic [OPC_W-1:0]  opc;
  logic [OPC_W-1:0]  opc_in;
  logic              jump, nop, taken, fire, leave, step_ok;
  logic              pc_clr, pc_load, pc_inc, pc_illegal;
  logic [ADDR_W-1:0] pc;

  assign opc    = ir[INSTR_W-1 -: OPC_W];
  assign opc_in = instr_in[INSTR_W-1 -: OPC_W];
  assign jump   = is_jump(opc);
  assign nop    = (opc == OPC_NOP);
  assign taken  = ((opc == OPC_JUMPZ) && z_flag) || ((opc == OPC_JUMPNZ) && !z_flag);

`ifdef INSTR_SEQ_STEP_EN
  assign step_ok = !step_mode || step;
`else
  assign step_ok = 1'b1;
`endif

  // resolved keeps the next pc from being recomputed while a step is awaited.
  assign fire    = (state == S_DISPATCH) && !resolved && (jump || nop || exec_done);
  assign leave   = (state == S_DISPATCH) && (fire || resolved) && (nop || step_ok);
  assign pc_clr  = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign pc_load = fire && jump && taken;
  assign pc_inc  = fire && !nop && !(jump && taken);

  pc_unit #(
    .ADDR_W    (ADDR_W),
    .INST_DEPTH(INST_DEPTH)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (pc_clr),
    .load    (pc_load),
    .load_val(ADDR_W'(ir[OPR_W-1:0])),
    .inc     (pc_inc),
    .pc      (pc),
    .illegal (pc_illegal)
  );

  // The pc register doubles as the RAM address, so a jump target is on the bus in the very next FETCH.
  assign instr_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ir          <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      retired     <= '0;
      resolved    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_FETCH;
            busy    <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
            retired <= '0;
          end
        end
        S_FETCH: begin
          if (pc_illegal) begin
            err   <= 1'b1;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          ir          <= instr_in;
          instr_valid <= !(is_jump(opc_in) || (opc_in == OPC_NOP));
          resolved    <= 1'b0;
          state       <= S_DISPATCH;
        end
        S_DISPATCH: begin
          if (fire) begin
            retired     <= retired + 16'd1;
            instr_valid <= 1'b0;
            resolved    <= 1'b1;
          end
          if (leave) begin
            if (nop) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
